// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg: shared FSM encoding and width helpers for the byte serializer
package byte_serializer_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  function automatic int nbytes(input int data_w, input int byte_w);
    return data_w / byte_w;
  endfunction
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam int LEVEL_W = level_w(4);
endpackage

// File: rtl/byte_serializer_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; dout is valid whenever level>0
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      level <= level + LW'(push) - LW'(pop);
    end
  end
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: buffers sampled words and emits them LSB byte first on a valid/ready stream
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BYTE_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [DATA_W-1:0]      x,
  output logic [BYTE_W-1:0]      m_data,
  output logic                   m_valid,
  output logic                   m_last,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int NB = nbytes(DATA_W, BYTE_W);
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int LW = level_w(DEPTH);
  state_t state, state_nx;
  logic [DATA_W-1:0] shift, shift_nx, head;
  logic [IW-1:0] idx, idx_nx;
  logic push, pop, fire, last, adv;
  // fullness is judged on the registered level only; a same-cycle pop never makes room
  assign push = en && level < LW'(DEPTH);
  assign fire = m_valid && m_ready;
  assign last = idx == IW'(NB - 1);
  assign pop = (state == IDLE || (fire && last)) && level != '0;
  assign adv = fire && !last;
  assign shift_nx = pop ? head : adv ? shift >> BYTE_W : shift;
  assign idx_nx = pop ? '0 : adv ? idx + 1'b1 : idx;
  assign state_nx = pop ? SHIFT : (fire && last) ? IDLE : state;
  sync_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(x), .pop(pop), .dout(head), .level(level)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shift <= '0;
      idx <= '0;
      m_data <= '0;
      m_valid <= 1'b0;
      m_last <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      shift <= shift_nx;
      idx <= idx_nx;
      m_data <= shift_nx[BYTE_W-1:0];
      m_valid <= state_nx == SHIFT;
      m_last <= state_nx == SHIFT && idx_nx == IW'(NB - 1);
      overflow <= overflow | (en && level == LW'(DEPTH));
    end
  end
endmodule
